// File: rtl/dm_pkg.sv
// Shared definitions for the data memory bank: sequencer states, datapath
// default widths and the bytes-per-word helper.
package dm_pkg;

    localparam int unsigned DM_DATA_W = 16;
    localparam int unsigned DM_ADDR_W = 10;
    localparam int unsigned DM_DEPTH  = 1024;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dm_state_e;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dm_byte_parity.sv
// Even-parity generator for one byte of the data memory bank.
// Only present when DATA_MEM_PARITY_EN is defined, the only build that uses it.
`ifdef DATA_MEM_PARITY_EN
module dm_byte_parity (
    input  logic [7:0] data,
    output logic       parity
);

    assign parity = ^data;

endmodule
`endif

// File: rtl/data_mem_bank.sv
// Single-port data memory with byte enables, post-reset clear sequencer and a
// registered read response. Optional per-byte parity under DATA_MEM_PARITY_EN.
module data_mem_bank
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W = DM_DATA_W,
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DEPTH  = DM_DEPTH
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_we,
    input  logic [ADDR_W-1:0]                   req_addr,
    input  logic [DATA_W-1:0]                   req_wdata,
    input  logic [bytes_per_word(DATA_W)-1:0]   req_be,
`ifdef DATA_MEM_PARITY_EN
    input  logic                                perr_inj,
`endif
    output logic                                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                rsp_err,
    output logic                                init_done
);

    localparam int unsigned NB    = bytes_per_word(DATA_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    dm_state_e         state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              ready_d;
    logic              clr_we_c;

    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;
    logic              acc_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic [DATA_W-1:0] rd_word_c;
    logic              perr_c;

    assign in_range_c = (64'(req_addr) < 64'(DEPTH));
    assign idx_c      = req_addr[IDX_W-1:0];
    assign acc_c      = req_valid && req_ready;
    assign wr_acc_c   = acc_c && req_we && in_range_c;
    assign rd_acc_c   = acc_c && !req_we;
    assign rd_word_c  = mem[idx_c];

`ifdef DATA_MEM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] wr_par_c;
    logic [NB-1:0] rd_par_c;

    for (genvar i = 0; i < NB; i++) begin : g_par
        dm_byte_parity u_wr_par (.data(req_wdata[8*i +: 8]), .parity(wr_par_c[i]));
        dm_byte_parity u_rd_par (.data(rd_word_c[8*i +: 8]), .parity(rd_par_c[i]));
    end

    // Out-of-range reads already flag an error; parity only judges real words.
    assign perr_c = in_range_c && (|(rd_par_c ^ mem_par[idx_c]));
`else
    assign perr_c = 1'b0;
`endif

    // Clear sequencer: one word per cycle, then RUN until the next reset.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_c = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_c = 1'b1;
                ptr_d    = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            req_ready <= ready_d;
            init_done <= ready_d;
        end
    end

    // Storage is never reset; the sequencer clears it instead.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[ptr_q] <= '0;
`ifdef DATA_MEM_PARITY_EN
            mem_par[ptr_q] <= '0;
`endif
        end else if (wr_acc_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (req_be[i]) begin
                    mem[idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef DATA_MEM_PARITY_EN
                    mem_par[idx_c][i] <= wr_par_c[i] ^ perr_inj;
`endif
                end
            end
        end
    end

    // Read response: one-cycle pulse, data held between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= rd_acc_c;
            if (rd_acc_c) begin
                rsp_rdata <= in_range_c ? rd_word_c : '0;
                rsp_err   <= !in_range_c || perr_c;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_bank.sv
// Scoreboard bench for data_mem_bank (DEPTH=16, ADDR_W=5, DATA_W=16); the
// parity scenario is included when DATA_MEM_PARITY_EN is defined.
module tb_data_mem_bank;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [1:0]        req_be = '0;
`ifdef DATA_MEM_PARITY_EN
    logic              perr_inj = 1'b0;
`endif
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    data_mem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
`ifdef DATA_MEM_PARITY_EN
        .perr_inj  (perr_inj),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int unsigned       cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest outstanding read.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn && rsp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h, expected no response", rsp_rdata);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_latency", cyc, e.cyc);
            end
        end
    end

    // One request per call; a read pushes its expected response.
    task automatic req(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [1:0] be,
                       input logic [DATA_W-1:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (!we) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 16);
        check("init_done_after_clear", 32'(init_done), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        #10;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_init_done", 32'(init_done), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        @(negedge clk);
        rstn = 1'b1;
        wait_init("clear_cycles_first");

        for (int a = 0; a < 16; a++) req(1'b0, 5'(a), '0, 2'b00, 16'h0000, 1'b0);

        req(1'b1, 5'd5, 16'hBEEF, 2'b11, '0, 1'b0);
        req(1'b0, 5'd5, '0, 2'b00, 16'hBEEF, 1'b0);
        req(1'b1, 5'd5, 16'h1234, 2'b01, '0, 1'b0);
        req(1'b0, 5'd5, '0, 2'b00, 16'hBE34, 1'b0);
        req(1'b1, 5'd5, 16'hFFFF, 2'b00, '0, 1'b0);
        req(1'b0, 5'd5, '0, 2'b00, 16'hBE34, 1'b0);
        req(1'b1, 5'd5, 16'hAB00, 2'b10, '0, 1'b0);
        req(1'b0, 5'd5, '0, 2'b00, 16'hAB34, 1'b0);
        req(1'b1, 5'd15, 16'hA5A5, 2'b11, '0, 1'b0);
        req(1'b0, 5'd15, '0, 2'b00, 16'hA5A5, 1'b0);
        idle(2);

        req(1'b1, 5'd20, 16'h5555, 2'b11, '0, 1'b0);
        req(1'b0, 5'd20, '0, 2'b00, 16'h0000, 1'b1);
        req(1'b0, 5'd16, '0, 2'b00, 16'h0000, 1'b1);
        req(1'b0, 5'd31, '0, 2'b00, 16'h0000, 1'b1);
        req(1'b0, 5'd4, '0, 2'b00, 16'h0000, 1'b0);
        req(1'b0, 5'd5, '0, 2'b00, 16'hAB34, 1'b0);
        idle(3);
        check("idle_rsp_valid", 32'(rsp_valid), 0);
        check("idle_rsp_rdata_hold", 32'(rsp_rdata), 32'h0000AB34);

`ifdef DATA_MEM_PARITY_EN
        perr_inj = 1'b1;
        req(1'b1, 5'd3, 16'h00FF, 2'b11, '0, 1'b0);
        perr_inj = 1'b0;
        req(1'b0, 5'd3, '0, 2'b00, 16'h00FF, 1'b1);
        req(1'b1, 5'd3, 16'h00FF, 2'b11, '0, 1'b0);
        req(1'b0, 5'd3, '0, 2'b00, 16'h00FF, 1'b0);
        idle(2);
`endif

        // Reset in the middle of the clear sequence.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (7) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midclear_req_ready", 32'(req_ready), 0);
        check("midclear_init_done", 32'(init_done), 0);
        @(negedge clk);
        rstn = 1'b1;
        wait_init("clear_cycles_after_midclear_reset");
        req(1'b0, 5'd5, '0, 2'b00, 16'h0000, 1'b0);

        // Reset while a read response is on the bus.
        req(1'b1, 5'd15, 16'h1111, 2'b11, '0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd15;
        @(posedge clk);
        #1;
        check("midrsp_rsp_valid_before", 32'(rsp_valid), 1);
        check("midrsp_rsp_rdata_before", 32'(rsp_rdata), 32'h00001111);
        #1 rstn = 1'b0;
        #1;
        check("midrsp_rsp_valid_dropped", 32'(rsp_valid), 0);
        check("midrsp_rsp_rdata_cleared", 32'(rsp_rdata), 0);
        @(negedge clk);
        req_valid = 1'b0;
        rstn = 1'b1;
        wait_init("clear_cycles_after_midrsp_reset");
        req(1'b0, 5'd15, '0, 2'b00, 16'h0000, 1'b0);
        idle(4);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
